// File: rtl/pulse_receiver_symbol_decoder.sv
// Pulse-width symbol decoder: measures line pulses, classifies them into
// 2-bit symbols and packs 16 per word behind a single-entry valid/ready buffer.
module pulse_receiver_symbol_decoder #(
    parameter int DUR_W   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sig_in,
    input  logic               invert_input,
    input  logic               idle_level,
    input  logic [PRESC_W-1:0] prescaler,
    input  logic [DUR_W-1:0]   threshold_low,
    input  logic [DUR_W-1:0]   threshold_high,
    input  logic [DUR_W-1:0]   timeout,
    output logic [31:0]        word_out,
    output logic [4:0]         word_count,
    output logic               word_last,
    output logic               word_valid,
    input  logic               word_ready,
    output logic               overflow,
    input  logic               clear_overflow
);

    typedef enum logic {S_IDLE, S_MEASURE} state_t;

    state_t           state_q, state_d;
    logic [14:0]      presc_q;
    logic [14:0]      presc_mask;
    logic             tick;
    logic             sig_eff;
    logic             level_q;
    logic             edge_det;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [DUR_W-1:0] thr;
    logic [1:0]       sym;
    logic [3:0]       idx_q, idx_d;
    logic [31:0]      shift_q, shift_d;
    logic [31:0]      push_word;
    logic [4:0]       push_count;
    logic             push, push_last;
    logic             tmo_hit;
    logic             drop;

    assign presc_mask = ~(15'h7fff << prescaler);
    assign tick       = (presc_q & presc_mask) == 15'd0;
    assign sig_eff    = sig_in ^ invert_input;
    assign edge_det   = sig_eff != level_q;
    assign thr        = level_q ? threshold_high : threshold_low;
    assign sym        = {level_q, dur_q > thr};
    assign tmo_hit    = (timeout != '0) && (level_q == idle_level)
                     && (dur_q == timeout);
    assign drop       = push && word_valid && !word_ready;

    // Duration restarts on every edge and saturates instead of wrapping.
    always_comb begin
        dur_d = dur_q;
        if (edge_det)
            dur_d = {{(DUR_W-1){1'b0}}, tick};
        else if (tick && dur_q != '1)
            dur_d = dur_q + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        push       = 1'b0;
        push_word  = shift_q;
        push_count = {1'b0, idx_q};
        push_last  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (edge_det && sig_eff != idle_level)
                    state_d = S_MEASURE;
            end
            S_MEASURE: begin
                if (edge_det) begin
                    shift_d = shift_q | ({30'd0, sym} << {idx_q, 1'b0});
                    idx_d   = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        push       = 1'b1;
                        push_word  = shift_d;
                        push_count = 5'd16;
                        shift_d    = '0;
                    end
                end else if (tmo_hit) begin
                    // A frame ending on a word boundary has nothing left to flush.
                    push      = idx_q != 4'd0;
                    push_last = 1'b1;
                    idx_d     = '0;
                    shift_d   = '0;
                    state_d   = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            level_q    <= idle_level;
            dur_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            word_out   <= '0;
            word_count <= '0;
            word_last  <= 1'b0;
            word_valid <= 1'b0;
        end else if (!en) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            level_q    <= sig_eff;
            dur_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            word_out   <= '0;
            word_count <= '0;
            word_last  <= 1'b0;
            word_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_q + 15'd1;
            level_q <= sig_eff;
            dur_q   <= dur_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            if (push && (!word_valid || word_ready)) begin
                word_out   <= push_word;
                word_count <= push_count;
                word_last  <= push_last;
                word_valid <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

    // A dropped word outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else if (en && drop)
            overflow <= 1'b1;
        else if (clear_overflow)
            overflow <= 1'b0;
    end

endmodule

// File: tb/tb_pulse_receiver_symbol_decoder.sv
// Bench for pulse_receiver_symbol_decoder: segment-level reference model,
// directed scenarios and randomized frames.
module tb_pulse_receiver_symbol_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sig_in;
    logic        invert_input;
    logic        idle_level;
    logic [3:0]  prescaler;
    logic [7:0]  threshold_low;
    logic [7:0]  threshold_high;
    logic [7:0]  timeout;
    logic [31:0] word_out;
    logic [4:0]  word_count;
    logic        word_last;
    logic        word_valid;
    logic        word_ready;
    logic        overflow;
    logic        clear_overflow;

    pulse_receiver_symbol_decoder #(.DUR_W(8), .PRESC_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .sig_in        (sig_in),
        .invert_input  (invert_input),
        .idle_level    (idle_level),
        .prescaler     (prescaler),
        .threshold_low (threshold_low),
        .threshold_high(threshold_high),
        .timeout       (timeout),
        .word_out      (word_out),
        .word_count    (word_count),
        .word_last     (word_last),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .overflow      (overflow),
        .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        int          cnt;
        bit          last;
    } wrd_t;

    int          checks = 0;
    int          errors = 0;
    wrd_t        exp_q[$];
    logic [31:0] obs_w[$];
    int          obs_c[$];
    bit          in_frame;
    int          nsym;
    logic [31:0] acc;
    int          phase;
    bit          hold;
    bit          exp_ovf;
    bit          prev_lvl;
    int          prev_t;
    wrd_t        mon_e;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void mpush(input logic [31:0] w, input int cnt,
                                  input bit last);
        wrd_t e;
        if (hold && exp_q.size() > 0) begin
            exp_ovf = 1'b1;
        end else begin
            e.w = w;
            e.cnt = cnt;
            e.last = last;
            exp_q.push_back(e);
        end
    endfunction

    function automatic void add_sym(input bit lvl, input int t);
        int d;
        int th;
        logic [31:0] s;
        d = (t > 255) ? 255 : t;
        th = lvl ? int'(threshold_high) : int'(threshold_low);
        s = {30'd0, lvl, (d > th)};
        acc = acc | (s << (2 * nsym));
        nsym++;
        if (nsym == 16) begin
            mpush(acc, 16, 1'b0);
            acc = '0;
            nsym = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (word_valid && word_ready) begin
            obs_w.push_back(word_out);
            obs_c.push_back(int'(word_count));
            if (exp_q.size() == 0) begin
                check("extra_word", 64'(word_out), 64'hdead);
            end else begin
                mon_e = exp_q.pop_front();
                check("word", 64'(word_out), 64'(mon_e.w));
                check("count", 64'(word_count), 64'(mon_e.cnt));
                check("last", 64'(word_last), 64'(mon_e.last));
            end
        end
    end

    // Drive one constant-level segment of n cycles (levels given as sig_eff).
    task automatic seg(input bit lvl, input int n);
        int t;
        bit tk;
        int mask;
        if (in_frame) add_sym(prev_lvl, prev_t);
        if (!in_frame && lvl != idle_level) begin
            in_frame = 1'b1;
            nsym = 0;
            acc = '0;
        end
        mask = (1 << int'(prescaler)) - 1;
        t = 0;
        for (int k = 0; k < n; k++) begin
            if (in_frame && lvl == idle_level && timeout != 8'd0
                && t == int'(timeout)) begin
                if (nsym > 0) mpush(acc, nsym, 1'b1);
                in_frame = 1'b0;
                nsym = 0;
                acc = '0;
            end
            tk = (phase & mask) == 0;
            sig_in = lvl ^ invert_input;
            @(posedge clk);
            #1;
            if (tk && t < 255) t++;
            phase = (phase + 1) & 32'h7fff;
        end
        prev_lvl = lvl;
        prev_t = t;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (en) phase = (phase + 1) & 32'h7fff;
        end
    endtask

    task automatic start_scn(input int p, input int tl, input int th,
                             input int to, input bit idl, input bit inv);
        en = 1'b0;
        prescaler = 4'(p);
        threshold_low = 8'(tl);
        threshold_high = 8'(th);
        timeout = 8'(to);
        idle_level = idl;
        invert_input = inv;
        sig_in = idl ^ inv;
        @(posedge clk);
        #1;
        en = 1'b1;
        phase = 0;
        in_frame = 1'b0;
        nsym = 0;
        acc = '0;
        obs_w.delete();
        obs_c.delete();
    endtask

    task automatic pulse_clear();
        clear_overflow = 1'b1;
        idle_cycles(1);
        clear_overflow = 1'b0;
        exp_ovf = 1'b0;
    endtask

    initial begin
        bit lvl;
        int n;
        int p;
        rst = 1'b1;
        en = 1'b0;
        sig_in = 1'b0;
        invert_input = 1'b0;
        idle_level = 1'b0;
        prescaler = '0;
        threshold_low = '0;
        threshold_high = '0;
        timeout = '0;
        word_ready = 1'b0;
        clear_overflow = 1'b0;
        hold = 1'b0;
        exp_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(word_valid), 64'd0);
        check("rst_word", 64'(word_out), 64'd0);
        check("rst_count", 64'(word_count), 64'd0);
        check("rst_last", 64'(word_last), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        rst = 1'b0;

        // Basic frame held in the buffer until the consumer is ready.
        start_scn(0, 4, 4, 10, 1'b0, 1'b0);
        hold = 1'b1;
        word_ready = 1'b0;
        seg(1'b0, 5);
        seg(1'b1, 3);
        seg(1'b0, 6);
        seg(1'b1, 7);
        seg(1'b0, 30);
        check("s1_valid", 64'(word_valid), 64'd1);
        check("s1_word", 64'(word_out), 64'h36);
        check("s1_count", 64'(word_count), 64'd3);
        check("s1_last", 64'(word_last), 64'd1);
        idle_cycles(5);
        check("s1_hold", 64'(word_out), 64'h36);
        check("s1_ovf", 64'(overflow), 64'(exp_ovf));
        word_ready = 1'b1;
        hold = 1'b0;
        idle_cycles(3);
        check("s1_drain", 64'(exp_q.size()), 64'd0);
        check("s1_fall", 64'(word_valid), 64'd0);

        // Full 16-symbol word followed by a one-symbol tail.
        start_scn(0, 4, 4, 10, 1'b0, 1'b0);
        seg(1'b0, 3);
        repeat (8) begin
            seg(1'b1, 2);
            seg(1'b0, 6);
        end
        seg(1'b1, 2);
        seg(1'b0, 30);
        idle_cycles(3);
        check("s2_n", 64'(obs_w.size()), 64'd2);
        check("s2_w0", 64'(obs_w[0]), 64'h66666666);
        check("s2_c0", 64'(obs_c[0]), 64'd16);
        check("s2_drain", 64'(exp_q.size()), 64'd0);

        // Two words with no consumer: second one is dropped.
        start_scn(0, 4, 4, 10, 1'b0, 1'b0);
        hold = 1'b1;
        word_ready = 1'b0;
        seg(1'b0, 3);
        repeat (8) begin
            seg(1'b1, 6);
            seg(1'b0, 2);
        end
        repeat (8) begin
            seg(1'b1, 2);
            seg(1'b0, 6);
        end
        seg(1'b1, 2);
        seg(1'b0, 30);
        check("s3_ovf", 64'(overflow), 64'(exp_ovf));
        check("s3_ovf1", 64'(overflow), 64'd1);
        check("s3_valid", 64'(word_valid), 64'd1);
        check("s3_word", 64'(word_out), 64'h33333333);
        pulse_clear();
        check("s3_clr", 64'(overflow), 64'd0);
        check("s3_kept", 64'(word_valid), 64'd1);
        check("s3_kept_w", 64'(word_out), 64'h33333333);
        word_ready = 1'b1;
        hold = 1'b0;
        idle_cycles(3);
        check("s3_drain", 64'(exp_q.size()), 64'd0);
        check("s3_n", 64'(obs_w.size()), 64'd1);

        // Prescaled durations around the high threshold.
        start_scn(2, 4, 3, 3, 1'b0, 1'b0);
        seg(1'b0, 4);
        seg(1'b1, 16);
        seg(1'b0, 8);
        seg(1'b1, 12);
        seg(1'b0, 40);
        idle_cycles(3);
        check("s4_w", 64'(obs_w[0]), 64'h23);
        check("s4_c", 64'(obs_c[0]), 64'd3);
        check("s4_drain", 64'(exp_q.size()), 64'd0);

        // Inverted input with idle-high line.
        start_scn(0, 4, 4, 10, 1'b1, 1'b1);
        seg(1'b1, 20);
        check("s5_quiet", 64'(word_valid), 64'd0);
        seg(1'b0, 3);
        seg(1'b1, 6);
        seg(1'b0, 7);
        seg(1'b1, 30);
        idle_cycles(3);
        check("s5_w", 64'(obs_w[0]), 64'h1c);
        check("s5_c", 64'(obs_c[0]), 64'd3);
        check("s5_drain", 64'(exp_q.size()), 64'd0);

        // Saturated pulse, then a frame abandoned by disabling.
        start_scn(0, 4, 4, 10, 1'b0, 1'b0);
        seg(1'b0, 3);
        seg(1'b1, 300);
        seg(1'b0, 30);
        idle_cycles(3);
        check("s6_sat", 64'(obs_w[0]), 64'h3);
        check("s6_sat_c", 64'(obs_c[0]), 64'd1);
        seg(1'b1, 3);
        seg(1'b0, 3);
        seg(1'b1, 3);
        seg(1'b0, 3);
        seg(1'b1, 3);
        seg(1'b0, 3);
        en = 1'b0;
        in_frame = 1'b0;
        nsym = 0;
        acc = '0;
        for (int k = 0; k < 4; k++) begin
            idle_cycles(1);
            check("s6_off", 64'(word_valid), 64'd0);
        end
        check("s6_ovf", 64'(overflow), 64'(exp_ovf));
        check("s6_drain", 64'(exp_q.size()), 64'd0);

        // Randomized frames.
        for (int r = 0; r < 10; r++) begin
            p = int'($urandom_range(0, 2));
            start_scn(p, int'($urandom_range(0, 8)),
                      int'($urandom_range(0, 8)),
                      int'($urandom_range(0, 12)),
                      1'($urandom % 2), 1'($urandom % 2));
            word_ready = 1'b1;
            hold = 1'b0;
            lvl = idle_level;
            seg(lvl, int'($urandom_range(1, 8)));
            n = int'($urandom_range(1, 40));
            for (int i = 0; i < n; i++) begin
                lvl = !lvl;
                seg(lvl, int'($urandom_range(1, 10 << p)));
            end
            if (lvl == idle_level) begin
                lvl = !lvl;
                seg(lvl, 3);
            end
            lvl = !lvl;
            seg(lvl, ((int'(timeout) + 2) << p) + 8);
            idle_cycles(4);
            check("rnd_drain", 64'(exp_q.size()), 64'd0);
            check("rnd_ovf", 64'(overflow), 64'(exp_ovf));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
